muldiv_unit: RTL and testbench

Iterative integer multiply/divide unit for the RV32M extension. It sits in the execute stage directly downstream of the postdecoder. It consumes the decoded `muldiv` flag and the `muldiv_op` one-hot vector, plus the two register operands. It stalls the pipeline until a single-cycle `ready` pulse delivers the 32-bit result for writeback.

---
 rtl/muldiv_unit_pkg.sv | 43 ++++
 rtl/muldiv_unit_core.sv | 44 ++++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The op vector is one-hot; field order fixes the packed bit positions.
package muldiv_unit_pkg;

   typedef struct packed {
      logic mul;
      logic mulh;
      logic mulhsu;
      logic mulhu;
      logic div;
      logic divu;
      logic rem;
      logic remu;
   } muldiv_op_type;

   typedef struct packed {
      logic          enable;
      muldiv_op_type op;
      logic [31:0]   rdata1;
      logic [31:0]   rdata2;
      logic          clear;
   } muldiv_in_type;

   typedef struct packed {
      logic [31:0] result;
      logic        ready;
      logic        busy;
   } muldiv_out_type;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
   localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// One unsigned iteration step of the multiply/divide datapath, purely combinational.
// Retires BITS_PER_CYCLE multiplier bits (shift-add) or quotient bits (restoring subtract).
module muldiv_unit_core #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        isDiv_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] operand_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] h;
   logic [31:0] l;
   logic [32:0] sum;
   logic [32:0] shifted;
   logic        ge;

   // Multiply: {hi,lo} is the 64-bit accumulator with the multiplier draining out of lo.
   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   always_comb begin
      h       = hi_i;
      l       = lo_i;
      sum     = '0;
      shifted = '0;
      ge      = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (isDiv_i) begin
            shifted = {h, l[31]};
            ge      = (shifted >= {1'b0, operand_i});
            h       = ge ? 32'(shifted - {1'b0, operand_i}) : shifted[31:0];
            l       = {l[30:0], ge};
         end else begin
            sum = {1'b0, h} + (l[0] ? {1'b0, operand_i} : 33'd0);
            h   = sum[32:1];
            l   = {sum[0], l[31:1]};
         end
      end
      hi_o = h;
      lo_o = l;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, counter, sign handling and fast paths.
// Operands are reduced to magnitudes at accept; the core only ever iterates unsigned.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  muldiv_op_type muldiv_op,
   input  logic [31:0]   rdata1,
   input  logic [31:0]   rdata2,
   input  logic          clear,
   output logic [31:0]   result,
   output logic          ready,
   output logic          busy
);

   localparam int ITER = 32 / BITS_PER_CYCLE;

   muldiv_in_type  req;
   muldiv_out_type rsp;

   muldiv_state_e state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic          isDiv_q, isDiv_d;
   logic          selRem_q, selRem_d;
   logic          selLow_q, selLow_d;
   logic          neg_q, neg_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   opnd_q, opnd_d;
   logic [31:0]   result_q, result_d;

   logic          opAny, isDivIn, signedA, signedB, s1, s2;
   logic [31:0]   magA, magB, fastRes;
   logic          divZero, overflow, accept;
   logic [31:0]   coreHi, coreLo;
   logic [63:0]   product;
   logic [31:0]   finalRes;

   assign req = '{enable: enable, op: muldiv_op, rdata1: rdata1, rdata2: rdata2, clear: clear};

   always_comb begin
      opAny    = |req.op;
      isDivIn  = req.op.div | req.op.divu | req.op.rem | req.op.remu;
      signedA  = req.op.mul | req.op.mulh | req.op.mulhsu | req.op.div | req.op.rem;
      signedB  = req.op.mul | req.op.mulh | req.op.div | req.op.rem;
      s1       = signedA & req.rdata1[31];
      s2       = signedB & req.rdata2[31];
      magA     = magnitude(req.rdata1, s1);
      magB     = magnitude(req.rdata2, s2);
      divZero  = isDivIn && (req.rdata2 == 32'd0);
      overflow = (req.op.div | req.op.rem) && (req.rdata1 == OVF_DIVIDEND)
                 && (req.rdata2 == OVF_DIVISOR);
      fastRes  = 32'd0;
      if (divZero) begin
         fastRes = (req.op.div | req.op.divu) ? 32'hFFFF_FFFF : req.rdata1;
      end else if (overflow) begin
         fastRes = req.op.div ? OVF_DIVIDEND : 32'd0;
      end
      accept   = (state_q == ST_IDLE) && req.enable && opAny && !req.clear;
   end

   muldiv_unit_core #(
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_core (
      .isDiv_i  (isDiv_q),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .operand_i(opnd_q),
      .hi_o     (coreHi),
      .lo_o     (coreLo)
   );

   // Sign correction is folded into the last iteration so DONE needs no extra cycle.
   always_comb begin
      product = {coreHi, coreLo};
      if (neg_q) begin
         product = ~product + 64'd1;
      end
      if (isDiv_q) begin
         finalRes = selRem_q ? magnitude(coreHi, neg_q) : magnitude(coreLo, neg_q);
      end else begin
         finalRes = selLow_q ? product[31:0] : product[63:32];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         isDiv_q  <= 1'b0;
         selRem_q <= 1'b0;
         selLow_q <= 1'b0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         isDiv_q  <= isDiv_d;
         selRem_q <= selRem_d;
         selLow_q <= selLow_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      isDiv_d  = isDiv_q;
      selRem_d = selRem_q;
      selLow_d = selLow_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               isDiv_d  = isDivIn;
               selRem_d = req.op.rem | req.op.remu;
               selLow_d = req.op.mul;
               neg_d    = (req.op.rem | req.op.remu) ? s1 : (s1 ^ s2);
               hi_d     = 32'd0;
               lo_d     = isDivIn ? magA : magB;
               opnd_d   = isDivIn ? magB : magA;
               if (divZero || overflow) begin
                  result_d = fastRes;
                  cnt_d    = 6'd0;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d    = 6'(ITER);
                  state_d  = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            hi_d  = coreHi;
            lo_d  = coreLo;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               result_d = finalRes;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A flush abandons whatever is in flight without delivering a result.
      if (req.clear) begin
         state_d = ST_IDLE;
         cnt_d   = 6'd0;
      end
   end

   always_comb begin
      rsp        = '0;
      rsp.result = result_q;
      rsp.ready  = (state_q == ST_DONE);
      rsp.busy   = (state_q == ST_BUSY);
   end

   assign result = rsp.result;
   assign ready  = rsp.ready;
   assign busy   = rsp.busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: three muldiv_unit instances (1, 2 and 4 bits per cycle) share stimulus
// and are checked every cycle against an arithmetic reference model of RV32M semantics.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int OP_NONE   = -1;
   localparam int OP_MUL    = 0;
   localparam int OP_MULH   = 1;
   localparam int OP_MULHSU = 2;
   localparam int OP_MULHU  = 3;
   localparam int OP_DIV    = 4;
   localparam int OP_DIVU   = 5;
   localparam int OP_REM    = 6;
   localparam int OP_REMU   = 7;

   localparam int MODE_NORMAL  = 0;
   localparam int MODE_CLEAR   = 1;
   localparam int MODE_RESET   = 2;
   localparam int MODE_POKE    = 3;
   localparam int MODE_CLRSAME = 4;

   logic          clock;
   logic          reset;
   logic          enable;
   muldiv_op_type muldiv_op;
   logic [31:0]   rdata1;
   logic [31:0]   rdata2;
   logic          clear;
   logic [31:0]   res [3];
   logic          rdy [3];
   logic          bsy [3];

   int            vecCount;
   int            missCount;
   bit            armed;
   int            k;
   int            expReadyAt [3];
   int            expBusyEnd [3];
   logic [31:0]   expRes;

   muldiv_unit #(.BITS_PER_CYCLE(1)) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .muldiv_op(muldiv_op),
      .rdata1(rdata1), .rdata2(rdata2), .clear(clear),
      .result(res[0]), .ready(rdy[0]), .busy(bsy[0]));

   muldiv_unit #(.BITS_PER_CYCLE(2)) dut2 (
      .clock(clock), .reset(reset), .enable(enable), .muldiv_op(muldiv_op),
      .rdata1(rdata1), .rdata2(rdata2), .clear(clear),
      .result(res[1]), .ready(rdy[1]), .busy(bsy[1]));

   muldiv_unit #(.BITS_PER_CYCLE(4)) dut4 (
      .clock(clock), .reset(reset), .enable(enable), .muldiv_op(muldiv_op),
      .rdata1(rdata1), .rdata2(rdata2), .clear(clear),
      .result(res[2]), .ready(rdy[2]), .busy(bsy[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic muldiv_op_type toOp(input int code);
      muldiv_op_type o;
      o = '0;
      case (code)
         OP_MUL:    o.mul    = 1'b1;
         OP_MULH:   o.mulh   = 1'b1;
         OP_MULHSU: o.mulhsu = 1'b1;
         OP_MULHU:  o.mulhu  = 1'b1;
         OP_DIV:    o.div    = 1'b1;
         OP_DIVU:   o.divu   = 1'b1;
         OP_REM:    o.rem    = 1'b1;
         OP_REMU:   o.remu   = 1'b1;
         default:   o        = '0;
      endcase
      return o;
   endfunction

   function automatic bit isFast(input int code, input logic [31:0] a, input logic [31:0] b);
      bit isDivOp;
      isDivOp = (code >= OP_DIV) && (code <= OP_REMU);
      return (isDivOp && b == 32'd0) ||
             ((code == OP_DIV || code == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] modelResult(input int code, input logic [31:0] a,
                                               input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      p  = '0;
      case (code)
         OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
         OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Per-cycle compare of every instance against the expectations armed by the stimulus.
   always @(negedge clock) begin
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            bit er;
            bit eb;
            er = (k == expReadyAt[i]);
            eb = (k >= 1) && (k <= expBusyEnd[i]);
            vecCount++;
            if (rdy[i] !== er || bsy[i] !== eb) begin
               missCount++;
               $display("[TB] FAIL handshake bpc%0d k=%0d: ready=%b busy=%b, expected ready=%b busy=%b",
                        1 << i, k, rdy[i], bsy[i], er, eb);
            end
            if (er) begin
               vecCount++;
               if (res[i] !== expRes) begin
                  missCount++;
                  $display("[TB] FAIL result bpc%0d: got 0x%08h, expected 0x%08h",
                           1 << i, res[i], expRes);
               end
            end
         end
         k++;
      end
   end

   task automatic applyStimulus(input int code, input logic [31:0] a, input logic [31:0] b,
                                input int mode, input int abortK);
      bit fast;
      @(posedge clock);
      #2;
      enable    = 1'b1;
      muldiv_op = toOp(code);
      rdata1    = a;
      rdata2    = b;
      clear     = (mode == MODE_CLRSAME);
      fast      = isFast(code, a, b);
      expRes    = modelResult(code, a, b);
      for (int i = 0; i < 3; i++) begin
         int lat;
         lat = fast ? 1 : (32 >> i) + 1;
         if (code == OP_NONE || mode == MODE_CLRSAME) begin
            expReadyAt[i] = -1;
            expBusyEnd[i] = 0;
         end else if (mode == MODE_CLEAR) begin
            expReadyAt[i] = -1;
            expBusyEnd[i] = abortK;
         end else if (mode == MODE_RESET) begin
            expReadyAt[i] = -1;
            expBusyEnd[i] = abortK - 1;
         end else begin
            expReadyAt[i] = lat;
            expBusyEnd[i] = lat - 1;
         end
      end
      k     = 0;
      armed = 1'b1;
      @(posedge clock);
      #2;
      enable    = 1'b0;
      muldiv_op = '0;
      clear     = 1'b0;
      if (mode == MODE_POKE) begin
         @(posedge clock);
         #2;
         enable    = 1'b1;
         muldiv_op = toOp(OP_MUL);
         rdata1    = 32'd9;
         rdata2    = 32'd9;
         @(posedge clock);
         #2;
         enable    = 1'b0;
         muldiv_op = '0;
      end else if (mode == MODE_CLEAR || mode == MODE_RESET) begin
         repeat (abortK - 1) @(posedge clock);
         #2;
         if (mode == MODE_CLEAR) begin
            clear = 1'b1;
            @(posedge clock);
            #2;
            clear = 1'b0;
         end else begin
            reset = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
               checkOutput($sformatf("async reset result bpc%0d", 1 << i), res[i], 32'd0);
               checkOutput($sformatf("async reset ready bpc%0d", 1 << i), {31'd0, rdy[i]}, 32'd0);
               checkOutput($sformatf("async reset busy bpc%0d", 1 << i), {31'd0, bsy[i]}, 32'd0);
            end
            @(posedge clock);
            #2;
            reset = 1'b1;
         end
      end
      repeat (40) @(posedge clock);
      armed = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecCount  = 0;
      missCount = 0;
      armed     = 1'b0;
      k         = 0;
      expRes    = '0;
      reset     = 1'b0;
      enable    = 1'b0;
      clear     = 1'b0;
      muldiv_op = '0;
      rdata1    = '0;
      rdata2    = '0;
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset result bpc%0d", 1 << i), res[i], 32'd0);
         checkOutput($sformatf("reset ready bpc%0d", 1 << i), {31'd0, rdy[i]}, 32'd0);
         checkOutput($sformatf("reset busy bpc%0d", 1 << i), {31'd0, bsy[i]}, 32'd0);
      end
      @(posedge clock);
      #2;
      reset = 1'b1;

      checkOutput("model mul",    modelResult(OP_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      checkOutput("model mulh",   modelResult(OP_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      checkOutput("model mulhsu", modelResult(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      checkOutput("model mulhu",  modelResult(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      checkOutput("model div",    modelResult(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      checkOutput("model rem",    modelResult(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      checkOutput("model divu",   modelResult(OP_DIVU, 32'd100, 32'd7), 32'd14);
      checkOutput("model remu",   modelResult(OP_REMU, 32'd100, 32'd7), 32'd2);

      applyStimulus(OP_MUL,    32'd7,          32'hFFFF_FFFD, MODE_NORMAL, 0);
      applyStimulus(OP_MULH,   32'h8000_0000,  32'h8000_0000, MODE_NORMAL, 0);
      applyStimulus(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, MODE_NORMAL, 0);
      applyStimulus(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, MODE_NORMAL, 0);
      applyStimulus(OP_MULHSU, 32'h8000_0000,  32'd2,         MODE_NORMAL, 0);
      applyStimulus(OP_DIV,    32'hFFFF_FFF9,  32'd2,         MODE_NORMAL, 0);
      applyStimulus(OP_REM,    32'hFFFF_FFF9,  32'd2,         MODE_NORMAL, 0);
      applyStimulus(OP_DIVU,   32'd100,        32'd7,         MODE_NORMAL, 0);
      applyStimulus(OP_REMU,   32'd100,        32'd7,         MODE_NORMAL, 0);
      applyStimulus(OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, MODE_NORMAL, 0);
      applyStimulus(OP_DIVU,   32'd5,          32'd0,         MODE_NORMAL, 0);
      applyStimulus(OP_REMU,   32'd5,          32'd0,         MODE_NORMAL, 0);
      applyStimulus(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, MODE_NORMAL, 0);
      applyStimulus(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, MODE_NORMAL, 0);
      applyStimulus(OP_REM,    32'h8000_0001,  32'd0,         MODE_NORMAL, 0);
      applyStimulus(OP_DIV,    32'd1000,       32'hFFFF_FFF9, MODE_POKE,   0);
      applyStimulus(OP_NONE,   32'd3,          32'd4,         MODE_NORMAL, 0);
      applyStimulus(OP_MUL,    32'd3,          32'd4,         MODE_CLRSAME, 0);
      applyStimulus(OP_DIV,    32'd1234567,    32'd89,        MODE_CLEAR,  6);
      applyStimulus(OP_MUL,    32'd3,          32'd4,         MODE_NORMAL, 0);
      applyStimulus(OP_DIV,    32'd1234567,    32'd89,        MODE_RESET,  5);
      applyStimulus(OP_MUL,    32'd3,          32'd4,         MODE_NORMAL, 0);
      applyStimulus(OP_REM,    32'hFFFF_FC00,  32'd7,         MODE_NORMAL, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
